// File: rtl/control_unit_pkg.sv
// Instruction set, state encoding and decode helpers shared by the control unit slice.
package control_unit_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned SEL_W  = 2;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_NAND = 4'h3;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h4;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h5;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h6;
    localparam logic [OP_W-1:0] OP_HLT  = 4'h7;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OP_W-1:0] OP_JZ   = 4'h9;
    localparam logic [OP_W-1:0] OP_JN   = 4'hA;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_FETCH2    = 3'd4,
        ST_HALT      = 3'd5
    } cuState_e;

    // True for opcodes that run through the ALU and write back its result.
    function automatic logic isAluOp(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
               (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction fetch, ALU control and register write-back signals of the control unit.
interface control_unit_if;

    logic [control_unit_pkg::DATA_W-1:0] pc;
    logic                                instrReq;
    logic [control_unit_pkg::DATA_W-1:0] instrData;
    logic                                instrValid;
    logic [control_unit_pkg::SEL_W-1:0]  regSelA;
    logic [control_unit_pkg::SEL_W-1:0]  regSelB;
    logic [control_unit_pkg::OP_W-1:0]   aluOpCode;
    logic                                zOutput;
    logic                                nOutput;
    logic                                regWrite;
    logic [control_unit_pkg::SEL_W-1:0]  regWriteSel;
    logic                                regWriteSrc;
    logic [control_unit_pkg::DATA_W-1:0] immediate;
    logic                                zFlag;
    logic                                nFlag;
    logic                                halted;

    modport master (
        output pc, instrReq, regSelA, regSelB, aluOpCode,
        output regWrite, regWriteSel, regWriteSrc, immediate,
        output zFlag, nFlag, halted,
        input  instrData, instrValid, zOutput, nOutput
    );

    modport slave (
        input  pc, instrReq, regSelA, regSelB, aluOpCode,
        input  regWrite, regWriteSel, regWriteSrc, immediate,
        input  zFlag, nFlag, halted,
        output instrData, instrValid, zOutput, nOutput
    );

endinterface

// File: rtl/control_unit_status_register.sv
// Zero/negative status flags with a load enable; reusable for wider condition codes.
module control_unit_status_register (
    input  logic clk,
    input  logic resetN,
    input  logic load,
    input  logic zIn,
    input  logic nIn,
    output logic zFlag,
    output logic nFlag
);

    // Flags update only when the sequencer asks for it.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            zFlag <= 1'b0;
            nFlag <= 1'b0;
        end else if (load) begin
            zFlag <= zIn;
            nFlag <= nIn;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit processor.
// Optional branch support (JMP/JZ/JN with a fetched target byte) is enabled by
// defining CONTROL_UNIT_BRANCH_EN; otherwise those opcodes decode as 1-byte NOPs.
module control_unit
    import control_unit_pkg::*;
(
    input  logic          clk,
    input  logic          resetN,
    control_unit_if.master bus
);

    cuState_e             state, stateNext;
    logic [DATA_W-1:0]    ir, irNext;
    logic [DATA_W-1:0]    pcQ, pcNext;
    logic [DATA_W-1:0]    immQ, immNext;
    logic                 instrReqQ, instrReqNext;
    logic [SEL_W-1:0]     selAQ, selANext;
    logic [SEL_W-1:0]     selBQ, selBNext;
    logic [SEL_W-1:0]     wrSelQ, wrSelNext;
    logic [OP_W-1:0]      aluOpQ, aluOpNext;
    logic                 regWriteQ, regWriteNext;
    logic                 wrSrcQ, wrSrcNext;
    logic                 haltedQ, haltedNext;
    logic                 flagLoad;
    logic                 zFlag, nFlag;
`ifdef CONTROL_UNIT_BRANCH_EN
    logic                 branchTaken;
`endif

    // Next state plus next value of every registered output.
    always_comb begin
        stateNext = state;
        irNext    = ir;
        pcNext    = pcQ;
        immNext   = immQ;
        flagLoad  = 1'b0;
`ifdef CONTROL_UNIT_BRANCH_EN
        branchTaken = 1'b0;
`endif

        case (state)
            ST_FETCH: begin
                if (bus.instrValid) begin
                    irNext    = bus.instrData;
                    pcNext    = pcQ + DATA_W'(1);
                    stateNext = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (ir[7:4])
                    OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR: stateNext = ST_EXECUTE;
                    OP_LDI:                                  stateNext = ST_FETCH2;
                    OP_HLT:                                  stateNext = ST_HALT;
`ifdef CONTROL_UNIT_BRANCH_EN
                    OP_JMP, OP_JZ, OP_JN:                    stateNext = ST_FETCH2;
`else
                    OP_JMP, OP_JZ, OP_JN:                    stateNext = ST_FETCH;
`endif
                    default:                                 stateNext = ST_FETCH;
                endcase
            end
            ST_EXECUTE: begin
                stateNext = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                flagLoad  = isAluOp(ir[7:4]);
                stateNext = ST_FETCH;
            end
            ST_FETCH2: begin
                if (bus.instrValid) begin
                    pcNext = pcQ + DATA_W'(1);
                    if (ir[7:4] == OP_LDI) begin
                        immNext   = bus.instrData;
                        stateNext = ST_WRITEBACK;
                    end else begin
`ifdef CONTROL_UNIT_BRANCH_EN
                        case (ir[7:4])
                            OP_JMP:  branchTaken = 1'b1;
                            OP_JZ:   branchTaken = zFlag;
                            OP_JN:   branchTaken = nFlag;
                            default: branchTaken = 1'b0;
                        endcase
                        if (branchTaken) begin
                            pcNext = bus.instrData;
                        end
`endif
                        stateNext = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                stateNext = ST_HALT;
            end
            default: begin
                stateNext = ST_FETCH;
            end
        endcase

        instrReqNext = (stateNext == ST_FETCH) || (stateNext == ST_FETCH2);
        regWriteNext = (stateNext == ST_WRITEBACK);
        wrSelNext    = regWriteNext ? irNext[3:2] : wrSelQ;
        wrSrcNext    = regWriteNext && (irNext[7:4] == OP_LDI);
        aluOpNext    = ((stateNext == ST_DECODE) || (stateNext == ST_EXECUTE) ||
                        (stateNext == ST_WRITEBACK)) ? irNext[7:4] : '0;
        selANext     = (stateNext == ST_DECODE) ? irNext[3:2] : selAQ;
        selBNext     = (stateNext == ST_DECODE) ? irNext[1:0] : selBQ;
        haltedNext   = (stateNext == ST_HALT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= ST_FETCH;
            ir        <= '0;
            pcQ       <= '0;
            immQ      <= '0;
            instrReqQ <= 1'b1;
            selAQ     <= '0;
            selBQ     <= '0;
            wrSelQ    <= '0;
            aluOpQ    <= '0;
            regWriteQ <= 1'b0;
            wrSrcQ    <= 1'b0;
            haltedQ   <= 1'b0;
        end else begin
            state     <= stateNext;
            ir        <= irNext;
            pcQ       <= pcNext;
            immQ      <= immNext;
            instrReqQ <= instrReqNext;
            selAQ     <= selANext;
            selBQ     <= selBNext;
            wrSelQ    <= wrSelNext;
            aluOpQ    <= aluOpNext;
            regWriteQ <= regWriteNext;
            wrSrcQ    <= wrSrcNext;
            haltedQ   <= haltedNext;
        end
    end

    control_unit_status_register uStatus (
        .clk    (clk),
        .resetN (resetN),
        .load   (flagLoad),
        .zIn    (bus.zOutput),
        .nIn    (bus.nOutput),
        .zFlag  (zFlag),
        .nFlag  (nFlag)
    );

    assign bus.pc          = pcQ;
    assign bus.instrReq    = instrReqQ;
    assign bus.regSelA     = selAQ;
    assign bus.regSelB     = selBQ;
    assign bus.aluOpCode   = aluOpQ;
    assign bus.regWrite    = regWriteQ;
    assign bus.regWriteSel = wrSelQ;
    assign bus.regWriteSrc = wrSrcQ;
    assign bus.immediate   = immQ;
    assign bus.zFlag       = zFlag;
    assign bus.nFlag       = nFlag;
    assign bus.halted      = haltedQ;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues expected fetches and
// write-backs, a negedge monitor compares them as the DUT presents them.
module tb_control_unit;

    logic clk;
    logic resetN;

    control_unit_if bus ();

    control_unit dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        int         delta;
    } fetchExpT;

    typedef struct {
        logic [1:0] sel;
        logic       src;
        logic [7:0] imm;
        logic [3:0] op;
        logic [1:0] sa;
        logic [1:0] sb;
        int         delta;
    } writeExpT;

    fetchExpT   fetchQ[$];
    writeExpT   writeQ[$];
    fetchExpT   fCur;
    writeExpT   wCur;
    int         nCompared   = 0;
    int         nMismatched = 0;
    int         cyc         = 0;
    int         lastHs      = 0;
    logic       prevWrite   = 1'b0;
    logic [7:0] pcExp;
    int         dNext;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare write-backs and fetch handshakes against the queues.
    always @(negedge clk) begin
        if (resetN === 1'b1) begin
            if (bus.regWrite === 1'b1) begin
                check("writeNotBackToBack", 32'(prevWrite), 32'd0);
                if (writeQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("FAIL unexpectedWrite: got regWrite sel %0d, required none", bus.regWriteSel);
                end else begin
                    wCur = writeQ.pop_front();
                    check("writeSel", 32'(bus.regWriteSel), 32'(wCur.sel));
                    check("writeSrc", 32'(bus.regWriteSrc), 32'(wCur.src));
                    check("writeLatency", 32'(cyc - lastHs), 32'(wCur.delta));
                    if (wCur.src) begin
                        check("writeImmediate", 32'(bus.immediate), 32'(wCur.imm));
                    end else begin
                        check("writeAluOp", 32'(bus.aluOpCode), 32'(wCur.op));
                        check("writeSelA", 32'(bus.regSelA), 32'(wCur.sa));
                        check("writeSelB", 32'(bus.regSelB), 32'(wCur.sb));
                    end
                end
            end
            if (bus.instrReq === 1'b1 && bus.instrValid === 1'b1) begin
                if (fetchQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("FAIL unexpectedFetch: got fetch at pc 0x%0h, required none", bus.pc);
                end else begin
                    fCur = fetchQ.pop_front();
                    check("fetchPc", 32'(bus.pc), 32'(fCur.pc));
                    if (fCur.delta >= 0) begin
                        check("fetchSpacing", 32'(cyc - lastHs), 32'(fCur.delta));
                    end
                end
                lastHs = cyc;
            end
        end
        prevWrite = (resetN === 1'b1) && (bus.regWrite === 1'b1);
    end

    task automatic waitReq();
        int guard = 0;
        while (bus.instrReq !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (bus.instrReq !== 1'b1) begin
            nCompared++;
            nMismatched++;
            $display("FAIL reqTimeout: instrReq %b after %0d cycles, required 1", bus.instrReq, guard);
        end
    endtask

    task automatic fetchByte(input logic [7:0] d, input int waits);
        waitReq();
        for (int i = 0; i < waits; i++) begin
            bus.instrValid = 1'b0;
            bus.instrData  = 8'hEE;
            @(posedge clk); #1;
        end
        bus.instrValid = 1'b1;
        bus.instrData  = d;
        @(posedge clk); #1;
        bus.instrValid = 1'b0;
        bus.instrData  = 8'hEE;
    endtask

    // Queue the expected fetch, serve the byte, advance the pc model.
    task automatic issue(input logic [7:0] d, input int waits, input int dAfter);
        fetchExpT f;
        f.pc    = pcExp;
        f.delta = (dNext < 0) ? -1 : dNext + waits;
        fetchQ.push_back(f);
        fetchByte(d, waits);
        pcExp = pcExp + 8'd1;
        dNext = dAfter;
    endtask

    task automatic expectWrite(input logic [1:0] sel, input logic src, input logic [7:0] imm,
                               input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                               input int delta);
        writeExpT w;
        w.sel = sel; w.src = src; w.imm = imm; w.op = op; w.sa = sa; w.sb = sb; w.delta = delta;
        writeQ.push_back(w);
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "Pc"}, 32'(bus.pc), 32'd0);
        check({tag, "Req"}, 32'(bus.instrReq), 32'd1);
        check({tag, "Others"}, 32'({bus.regSelA, bus.regSelB, bus.aluOpCode, bus.regWrite,
                                    bus.regWriteSel, bus.regWriteSrc, bus.immediate,
                                    bus.zFlag, bus.nFlag, bus.halted}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        resetN         = 1'b0;
        bus.instrValid = 1'b0;
        bus.instrData  = 8'h00;
        bus.zOutput    = 1'b0;
        bus.nOutput    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        resetN = 1'b1;
        pcExp  = 8'h00;
        dNext  = -1;

        // ADD r1,r2
        expectWrite(2'd1, 1'b0, 8'h00, 4'h1, 2'd1, 2'd2, 3);
        issue(8'h16, 0, 4);
        check("addPc", 32'(bus.pc), 32'd1);

        // SUB r0,r0 with zero result
        bus.zOutput = 1'b1; bus.nOutput = 1'b0;
        expectWrite(2'd0, 1'b0, 8'h00, 4'h2, 2'd0, 2'd0, 3);
        issue(8'h20, 0, 4);
        waitReq();
        check("subZFlag", 32'(bus.zFlag), 32'd1);
        check("subNFlag", 32'(bus.nFlag), 32'd0);

        // NOP must not touch flags even with different ALU outputs
        bus.zOutput = 1'b0; bus.nOutput = 1'b1;
        issue(8'hF5, 0, 2);
        waitReq();
        check("nopZFlag", 32'(bus.zFlag), 32'd1);
        check("nopNFlag", 32'(bus.nFlag), 32'd0);

        // NAND r2,r3 with negative result
        expectWrite(2'd2, 1'b0, 8'h00, 4'h3, 2'd2, 2'd3, 3);
        issue(8'h3B, 0, 4);
        waitReq();
        check("nandFlags", 32'({bus.zFlag, bus.nFlag}), 32'b01);

        // LDI r3, 0x80 with two wait cycles on the second byte
        bus.zOutput = 1'b1; bus.nOutput = 1'b0;
        issue(8'h6C, 0, 2);
        expectWrite(2'd3, 1'b1, 8'h80, 4'h0, 2'd0, 2'd0, 1);
        issue(8'h80, 2, 2);
        waitReq();
        check("ldiFlagsKept", 32'({bus.zFlag, bus.nFlag}), 32'b01);

`ifdef CONTROL_UNIT_BRANCH_EN
        // JZ 0x10 not taken (zFlag = 0)
        issue(8'h90, 0, 2);
        issue(8'h10, 0, 1);
        check("jzNotTakenPc", 32'(bus.pc), 32'h08);
        // SUB r1,r1 sets zFlag, then JZ 0x10 taken
        bus.zOutput = 1'b1; bus.nOutput = 1'b0;
        expectWrite(2'd1, 1'b0, 8'h00, 4'h2, 2'd1, 2'd1, 3);
        issue(8'h25, 0, 4);
        issue(8'h90, 0, 2);
        issue(8'h10, 0, 1);
        pcExp = 8'h10;
        check("jzTakenPc", 32'(bus.pc), 32'h10);
`else
        // JZ is a one-byte NOP without branch support
        issue(8'h90, 0, 2);
        waitReq();
        check("jzNopPc", 32'(bus.pc), 32'h07);
`endif

        // Run NOPs up to pc 255, then one more to see the wrap
        while (pcExp != 8'hFF) begin
            issue(8'hF0, 0, 2);
        end
        issue(8'hF0, 0, 2);
        check("pcWrap", 32'(bus.pc), 32'h00);

        // HLT at pc 0: terminal, ignores offered instruction bytes
        issue(8'h70, 0, 2);
        bus.instrValid = 1'b1;
        bus.instrData  = 8'h16;
        @(posedge clk); #1;
        check("halted", 32'(bus.halted), 32'd1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.instrReq !== 1'b0 || bus.regWrite !== 1'b0 || bus.halted !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        check("haltQuietCycles", 32'(bad), 32'd0);
        check("haltPc", 32'(bus.pc), 32'h01);

        // Reset leaves HALT
        resetN = 1'b0;
        bus.instrValid = 1'b0;
        @(posedge clk); #1;
        checkResetState("haltReset");
        resetN = 1'b1;
        pcExp  = 8'h00;
        dNext  = -1;

        // Reset in EXECUTE drops the write and ignores a same-cycle instrValid
        issue(8'h16, 0, 4);
        @(posedge clk); #1;
        check("execAluOp", 32'(bus.aluOpCode), 32'h1);
        check("execSels", 32'({bus.regSelA, bus.regSelB}), 32'b0110);
        resetN = 1'b0;
        bus.instrValid = 1'b1;
        bus.instrData  = 8'h25;
        @(posedge clk); #1;
        checkResetState("execReset");
        bus.instrValid = 1'b0;
        resetN = 1'b1;
        pcExp  = 8'h00;
        dNext  = -1;
        repeat (4) @(posedge clk);
        #1;
        check("afterResetPc", 32'(bus.pc), 32'h00);

        // Normal ADD after reset
        bus.zOutput = 1'b0; bus.nOutput = 1'b0;
        expectWrite(2'd1, 1'b0, 8'h00, 4'h1, 2'd1, 2'd2, 3);
        issue(8'h16, 0, 4);
        waitReq();
        check("finalFlags", 32'({bus.zFlag, bus.nFlag}), 32'b00);
        repeat (3) @(posedge clk);
        #1;
        check("fetchQueueDrained", 32'(fetchQ.size()), 32'd0);
        check("writeQueueDrained", 32'(writeQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Fetch/decode/execute sequencer for the 8-bit processor, directly upstream of `arithmeticLogicUnit`. It fetches 8-bit instructions over a valid-qualified memory port and drives the register-file read selects that produce the ALU's `inA`/`inB`. It drives the ALU `opCode`, latches the ALU `zOutput`/`nOutput` into status flags, and issues one register write-back per ALU instruction.

## Interface
- No parameters. Data width 8, opcode width 4, register-select width 2 (four registers), all fixed.
- `clk`  in  1  sole clock, all state updates on rising edge.
- `resetN`  in  1  reset, synchronous and active-low.
- `pc`  out  8  instruction address.
- `instrReq`  out  1  fetch request; high only in FETCH/FETCH2.
- `instrData`  in  8  instruction byte; `[7:4]` opcode, `[3:2]` rd/rsA, `[1:0]` rsB.
- `instrValid`  in  1  `instrData` valid this cycle; ignored when `instrReq` is low.
- `regSelA`  out  2  read select feeding ALU `inA`.
- `regSelB`  out  2  read select feeding ALU `inB`.
- `aluOpCode`  out  4  connects to ALU `opCode`.
- `zOutput`  in  1  ALU zero output.
- `nOutput`  in  1  ALU negative output.
- `regWrite`  out  1  one-cycle write strobe.
- `regWriteSel`  out  2  destination register.
- `regWriteSrc`  out  1  selects the write data source: 0 = ALU `out`, 1 = `immediate`.
- `immediate`  out  8  second instruction byte for the LDI instruction.
- `zFlag`  out  1  registered zero flag.
- `nFlag`  out  1  registered negative flag.
- `halted`  out  1  high in the HALT state.

## Operation
- States:
  - FETCH: `instrReq` is high. On `instrValid`, latch IR, `pc <= pc+1`, and go to DECODE. Otherwise hold with `pc` unchanged.
  - DECODE: drive `regSelA = IR[3:2]`, `regSelB = IR[1:0]`, and `aluOpCode = IR[7:4]`.
  - EXECUTE: ALU settles; outputs are held from DECODE.
  - WRITEBACK: `regWrite = 1`, `regWriteSel = IR[3:2]`, `regWriteSrc = 0`. `zFlag`/`nFlag` are loaded from `zOutput`/`nOutput`. Then go to FETCH.
  - FETCH2: second-byte fetch, with the same handshake as FETCH.
  - HALT: terminal.
- Opcodes in `instructionSet.vh`:
  - `ADD`, `SUB`, `NAND`, `SHL`, `SHR` take the ALU path DECODE → EXECUTE → WRITEBACK.
  - `LDI` (new): FETCH2 loads `immediate`, then WRITEBACK with `regWriteSrc = 1`. Flags are unchanged.
  - `HLT` (new): goes to HALT.
  - Branches are described under Configuration.
  - Any other opcode is a NOP: DECODE → FETCH, no write, no flag change.
- `pc` wraps 255 → 0 silently.
- `aluOpCode` outside DECODE/EXECUTE/WRITEBACK is 0. `regSelA`/`regSelB` hold their last value.
- Flags change only in WRITEBACK of an ALU opcode.
- In HALT, `instrReq = 0` and `regWrite = 0`. Only `resetN` exits HALT.

## Timing
- Reset values (sampled `resetN = 0` at an edge):
  - state FETCH, `pc = 0`, IR = 0;
  - `instrReq` = 1 in the first cycle after reset;
  - `regWrite = 0`, `regWriteSel = 0`, `regWriteSrc = 0`, `immediate = 0`;
  - `aluOpCode = 0`, `regSelA = 0`, `regSelB = 0`;
  - `zFlag = 0`, `nFlag = 0`, `halted = 0`.
- Reset mid-operation: the next edge restores reset values. A pending fetch is abandoned, and an `instrValid` in the same cycle is ignored. A `regWrite` in progress is dropped.
- Latency with zero-wait memory (`instrValid` in the first request cycle):
  - ALU instruction: 4 cycles, with `regWrite` in cycle 4.
  - LDI: 4 cycles (FETCH, DECODE, FETCH2, WRITEBACK).
  - NOP: 2 cycles.
- Each wait cycle with `instrValid = 0` adds exactly 1 cycle.
- `regWrite` is high for exactly one cycle per writing instruction. It is never asserted back-to-back.
- All outputs are registered. No combinational path from input to output.

## Configuration
- `CONTROL_UNIT_BRANCH_EN` defined:
  - `JMP`, `JZ`, `JN` (new opcodes) fetch a target byte via FETCH2.
  - `JMP` always loads `pc <= target`. `JZ` loads it if `zFlag`, `JN` if `nFlag`; otherwise `pc` stays at the already-incremented value.
  - Taken or not, a branch costs 3 cycles with zero-wait memory. No write, no flag change.
- Undefined: `JMP`/`JZ`/`JN` decode as a 1-byte NOP; the target byte is not fetched.

## Structure
- Opcode macros, including new `LDI`, `HLT`, `JMP`, `JZ`, `JN`, and state encodings live in shared `instructionSet.vh`.
- A single flat module. The one natural sub-module is `status_register` (`zFlag`/`nFlag` with load enable), kept separate so a later condition-code extension reuses it.

## Test plan
- Reset → `pc = 0`, `instrReq = 1`, all other outputs 0. Assert reset while in EXECUTE → next cycle FETCH, `pc = 0`, no `regWrite`.
- `ADD r1,r2` (zero-wait) → `aluOpCode = ADD`, `regSelA = 1`, `regSelB = 2`; `regWrite` in cycle 4 with `regWriteSel = 1`; `pc = 1`.
- `SUB r0,r0` with ALU `zOutput = 1`, `nOutput = 0` → `zFlag = 1` after WRITEBACK. A following NOP (e.g. opcode 0xF if unused) leaves `zFlag = 1`.
- `LDI r3` plus byte 0x80 with 2 wait cycles on the second byte → `immediate = 0x80`, `regWriteSrc = 1`, `regWriteSel = 3`, 6 cycles total.
- With `CONTROL_UNIT_BRANCH_EN`: `JZ` to 0x10 with `zFlag = 1` → `pc = 0x10`; with `zFlag = 0` → `pc = 2`. Without the macro, `JZ` → `pc = 1`, NOP.
- `pc = 255` fetch → `pc = 0`. `HLT` → `halted = 1`, `instrReq = 0` for 10+ cycles; reset clears it.
